// File: rtl/rubik_wcmd_fifo.sv
// Write-command FIFO for the Rubik write path: registered input stage, 1R1W RAM with
// registered write port and registered read output, valid/ready on both sides.
module rubik_wcmd_fifo #(
  parameter int WIDTH    = 11,
  parameter int DEPTH    = 256,
  parameter int WR_LIMIT = 0
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             idata_pvld,
  output logic             idata_prdy,
  input  logic [WIDTH-1:0] idata_pd,
  output logic             odata_pvld,
  input  logic             odata_prdy,
  output logic [WIDTH-1:0] odata_pd,
  input  logic [31:0]      pwrbus_ram_pd
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);
  localparam logic [CW-1:0] LIMIT_C = ((WR_LIMIT == 0) || (WR_LIMIT > DEPTH)) ?
                                      CW'(DEPTH) : CW'(WR_LIMIT);
  localparam logic [AW-1:0] ADR_LAST_C = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADR_ZERO_C = AW'(0);

  // Input holding stage and write side
  logic             idata_prdy_r;
  logic             pvld_in_r;
  logic [WIDTH-1:0] pd_in_r;
  logic             wr_busy_r;
  logic [CW-1:0]    wr_count_r;
  logic [AW-1:0]    wr_adr_r;
  logic             wr_pop_r;

  // Registered RAM write port
  logic             we_r;
  logic [AW-1:0]    wa_r;
  logic [WIDTH-1:0] di_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Read side
  logic             rd_push_r;
  logic [CW-1:0]    rd_count_r;
  logic [AW-1:0]    rd_adr_r;
  logic [AW-1:0]    ra_r;
  logic             pvld_p_r;
  logic             odata_pvld_r;
  logic [WIDTH-1:0] odata_pd_r;

  // Combinational next-state terms
  logic             reserve_s;
  logic             pop_s;
  logic [CW-1:0]    wr_count_nxt_s;
  logic             busy_nxt_s;
  logic             prdy_nxt_s;
  logic [CW-1:0]    rd_count_nxt_s;
  logic             rd_enable_s;
  logic             odata_pvld_nxt_s;
  logic             clk_en_s;
  logic             ram_pd_unused_s;

  function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] adr);
    return (adr == ADR_LAST_C) ? ADR_ZERO_C : adr + AW'(1);
  endfunction

  assign ram_pd_unused_s = ^pwrbus_ram_pd;

  assign reserve_s = pvld_in_r && !wr_busy_r;
  assign pop_s     = pvld_p_r && !(odata_pvld_r && !odata_prdy);

  // Write-side occupancy, busy flag and next input-ready value
  always_comb begin
    wr_count_nxt_s = wr_count_r;
    case ({reserve_s, wr_pop_r})
      2'b10:   wr_count_nxt_s = wr_count_r + ONE_C;
      2'b01:   wr_count_nxt_s = wr_count_r - ONE_C;
      default: wr_count_nxt_s = wr_count_r;
    endcase
    busy_nxt_s = (wr_count_nxt_s >= LIMIT_C);
    if (idata_pvld) begin
      prdy_nxt_s = !busy_nxt_s;
    end else begin
      prdy_nxt_s = !(pvld_in_r && busy_nxt_s && !reserve_s);
    end
  end

  // Read-side occupancy, RAM read enable and next output-valid value
  always_comb begin
    rd_count_nxt_s = rd_count_r;
    case ({rd_push_r, pop_s})
      2'b10:   rd_count_nxt_s = rd_count_r + ONE_C;
      2'b01:   rd_count_nxt_s = rd_count_r - ONE_C;
      default: rd_count_nxt_s = rd_count_r;
    endcase
    rd_enable_s      = (rd_count_nxt_s != ZERO_C) && (!pvld_p_r || pop_s);
    odata_pvld_nxt_s = pvld_p_r || (odata_pvld_r && !odata_prdy);
  end

  // Every state change is covered by one of these terms, so gating on them is invisible outside
  assign clk_en_s = idata_pvld || pvld_in_r || we_r || rd_push_r || pvld_p_r ||
                    wr_pop_r || odata_pvld_r || (busy_nxt_s != wr_busy_r) ||
                    (prdy_nxt_s != idata_prdy_r);

  // Input holding register, write-side counters and registered write port
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      idata_prdy_r <= 1'b1;
      pvld_in_r    <= 1'b0;
      pd_in_r      <= '0;
      wr_busy_r    <= 1'b0;
      wr_count_r   <= ZERO_C;
      wr_adr_r     <= ADR_ZERO_C;
      wr_pop_r     <= 1'b0;
      we_r         <= 1'b0;
      wa_r         <= ADR_ZERO_C;
      di_r         <= '0;
    end else if (clk_en_s) begin
      idata_prdy_r <= prdy_nxt_s;
      if (idata_prdy_r) begin
        pvld_in_r <= idata_pvld;
        if (idata_pvld) begin
          pd_in_r <= idata_pd;
        end
      end
      wr_busy_r  <= busy_nxt_s;
      wr_count_r <= wr_count_nxt_s;
      wr_pop_r   <= pop_s;
      we_r       <= reserve_s;
      if (reserve_s) begin
        wa_r     <= wr_adr_r;
        di_r     <= pd_in_r;
        wr_adr_r <= next_adr(wr_adr_r);
      end
    end
  end

  // RAM array write; storage itself carries no reset
  always_ff @(posedge nvdla_core_clk) begin
    if (we_r) begin
      mem_r[wa_r] <= di_r;
    end
  end

  // Read-side counters, prefetch flag and output register
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      rd_push_r    <= 1'b0;
      rd_count_r   <= ZERO_C;
      rd_adr_r     <= ADR_ZERO_C;
      ra_r         <= ADR_ZERO_C;
      pvld_p_r     <= 1'b0;
      odata_pvld_r <= 1'b0;
      odata_pd_r   <= '0;
    end else if (clk_en_s) begin
      rd_push_r  <= we_r;
      rd_count_r <= rd_count_nxt_s;
      pvld_p_r   <= (rd_count_nxt_s != ZERO_C);
      if (rd_enable_s) begin
        ra_r     <= rd_adr_r;
        rd_adr_r <= next_adr(rd_adr_r);
      end
      odata_pvld_r <= odata_pvld_nxt_s;
      if (pop_s) begin
        odata_pd_r <= mem_r[ra_r];
      end
    end
  end

  assign idata_prdy = idata_prdy_r;
  assign odata_pvld = odata_pvld_r;
  assign odata_pd   = odata_pd_r;

endmodule

// File: tb/tb_rubik_wcmd_fifo.sv
// Randomized self-checking bench for rubik_wcmd_fifo against a queue-based FIFO model.
module tb_rubik_wcmd_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        idata_pvld;
  logic        idata_prdy;
  logic [10:0] idata_pd;
  logic        odata_pvld;
  logic        odata_prdy;
  logic [10:0] odata_pd;
  logic [31:0] pwrbus_ram_pd;

  int n_checks = 0;
  int n_errors = 0;
  int n_in     = 0;
  int n_out    = 0;
  int cyc      = 0;

  logic [10:0] model_q[$];
  logic        stall_chk = 1'b0;
  logic [10:0] stall_pd  = 11'd0;

  always #5 clk = ~clk;

  rubik_wcmd_fifo dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .idata_pvld     (idata_pvld),
    .idata_prdy     (idata_prdy),
    .idata_pd       (idata_pd),
    .odata_pvld     (odata_pvld),
    .odata_prdy     (odata_prdy),
    .odata_pd       (odata_pd),
    .pwrbus_ram_pd  (pwrbus_ram_pd)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Record handshakes seen before the edge, advance one clock, then check stall stability.
  task automatic step();
    logic [10:0] exp_pd;
    if (!rst && odata_pvld && odata_prdy) begin
      if (model_q.size() == 0) begin
        check_val("spurious_out", 32'(model_q.size()), 32'd1);
      end else begin
        exp_pd = model_q.pop_front();
        check_val("out_data", 32'(odata_pd), 32'(exp_pd));
      end
      n_out++;
    end
    if (!rst && idata_pvld && idata_prdy) begin
      model_q.push_back(idata_pd);
      n_in++;
    end
    stall_chk = !rst && odata_pvld && !odata_prdy;
    stall_pd  = odata_pd;
    @(posedge clk);
    #1;
    cyc++;
    if (stall_chk) begin
      check_val("stall_vld", 32'(odata_pvld), 32'd1);
      check_val("stall_pd", 32'(odata_pd), 32'(stall_pd));
    end
  endtask

  initial begin
    int acc;
    int out0;
    int first_out;
    int last_out;
    int prdy_low;
    int nxt;

    rst           = 1'b1;
    idata_pvld    = 1'b0;
    idata_pd      = 11'd0;
    odata_prdy    = 1'b0;
    pwrbus_ram_pd = 32'd0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      step();
      check_val("idle_prdy", 32'(idata_prdy), 32'd1);
      check_val("idle_vld", 32'(odata_pvld), 32'd0);
    end

    // Single beat latency
    odata_prdy = 1'b1;
    idata_pvld = 1'b1;
    idata_pd   = 11'h5A3;
    step();
    idata_pvld = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      check_val($sformatf("lat_vld_%0d", k), 32'(odata_pvld), (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) check_val("lat_pd", 32'(odata_pd), 32'h5A3);
    end

    // Back-to-back stream 0..511
    out0 = n_out; nxt = 0; first_out = -1; last_out = -1; prdy_low = 0;
    for (int c = 0; c < 2000 && (n_out - out0) < 512; c++) begin
      idata_pvld = (nxt < 512);
      idata_pd   = 11'(nxt);
      if (idata_pvld && !idata_prdy) prdy_low++;
      if (idata_pvld && idata_prdy) nxt++;
      if (odata_pvld) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      step();
    end
    idata_pvld = 1'b0;
    check_val("stream_outs", 32'(n_out - out0), 32'd512);
    check_val("stream_span", 32'(last_out - first_out), 32'd511);
    check_val("stream_prdy_low", 32'(prdy_low), 32'd0);

    // Capacity with the output blocked
    odata_prdy = 1'b0; acc = 0;
    for (int c = 0; c < 400; c++) begin
      idata_pvld = (acc < 300);
      idata_pd   = 11'($urandom);
      if (idata_pvld && idata_prdy) acc++;
      step();
    end
    idata_pvld = 1'b0;
    check_val("cap_accepted", 32'(acc), 32'd258);
    check_val("cap_prdy", 32'(idata_prdy), 32'd0);
    check_val("cap_vld", 32'(odata_pvld), 32'd1);
    odata_prdy = 1'b1; out0 = n_out;
    for (int c = 0; c < 1000 && model_q.size() > 0; c++) step();
    for (int c = 0; c < 8; c++) step();
    check_val("cap_drained", 32'(n_out - out0), 32'd258);
    check_val("cap_prdy_back", 32'(idata_prdy), 32'd1);
    check_val("cap_vld_end", 32'(odata_pvld), 32'd0);

    // Random traffic on both sides
    acc = 0; out0 = n_out;
    for (int c = 0; c < 60000 && (acc < 10000 || model_q.size() > 0); c++) begin
      idata_pvld = (acc < 10000) && ($urandom_range(0, 1) == 1);
      idata_pd   = 11'($urandom);
      odata_prdy = ($urandom_range(0, 1) == 1);
      if (idata_pvld && idata_prdy) acc++;
      step();
    end
    idata_pvld = 1'b0;
    check_val("rand_accepted", 32'(acc), 32'd10000);
    check_val("rand_drained", 32'(n_out - out0), 32'd10000);

    // Reset with entries queued
    odata_prdy = 1'b0; acc = 0;
    for (int c = 0; c < 200 && acc < 100; c++) begin
      idata_pvld = 1'b1;
      idata_pd   = 11'($urandom);
      if (idata_prdy) acc++;
      step();
    end
    idata_pvld = 1'b0;
    step();
    check_val("pre_rst_acc", 32'(acc), 32'd100);
    check_val("pre_rst_vld", 32'(odata_pvld), 32'd1);
    rst = 1'b1;
    step();
    check_val("rst_vld", 32'(odata_pvld), 32'd0);
    check_val("rst_prdy", 32'(idata_prdy), 32'd1);
    model_q.delete();
    rst = 1'b0;
    odata_prdy = 1'b1; out0 = n_out;
    idata_pvld = 1'b1;
    idata_pd   = 11'h001;
    step();
    idata_pvld = 1'b0;
    for (int c = 0; c < 20; c++) step();
    check_val("post_rst_outs", 32'(n_out - out0), 32'd1);
    check_val("model_empty", 32'(model_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
